// File: rtl/lsq_coef_solver_pkg.sv
// Shared definitions for the Longstaff-Schwartz regression coefficient solver.
//   - FSM state encoding (3-bit) and the enum built on it
//   - operand formats of the inverse terms and the X'Y sums
//   - internal datapath widths (operand, product, accumulator)
package lsq_coef_solver_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL0 = 3'd1;
   localparam logic [2:0] S_MUL1 = 3'd2;
   localparam logic [2:0] S_MUL2 = 3'd3;
   localparam logic [2:0] S_MUL3 = 3'd4;
   localparam logic [2:0] S_OUT  = 3'd5;

   typedef enum logic [2:0] {
      IDLE = S_IDLE,
      MUL0 = S_MUL0,
      MUL1 = S_MUL1,
      MUL2 = S_MUL2,
      MUL3 = S_MUL3,
      OUT  = S_OUT
   } state_t;

   localparam int INV00_W    = 32;
   localparam int INV00_FRAC = 10;
   localparam int INV01_W    = 20;
   localparam int INV01_FRAC = 8;
   localparam int INV11_W    = 21;
   localparam int INV11_FRAC = 6;
   localparam int XTY_W      = 33;

   // Fraction bits of the price-domain sums produced by the XTX/XTY stages.
   localparam int PRICE_FRAC = 8;

   localparam int OPND_W = 34;
   localparam int PROD_W = 2 * OPND_W;
   localparam int ACC_W  = PROD_W + 1;

   function automatic logic [OPND_W-1:0] zext_xty(input logic [XTY_W-1:0] v);
      return {{(OPND_W-XTY_W){1'b0}}, v};
   endfunction

endpackage

// File: rtl/lsq_round_sat.sv
// Arithmetic right shift with half-up rounding and saturation to a signed
// OUT_W result. Purely combinational.
//   din  : signed IN_W value
//   dout : signed OUT_W value, round(din / 2^SHIFT) clamped to the OUT_W range
module lsq_round_sat #(
   parameter int IN_W  = 69,
   parameter int SHIFT = 2,
   parameter int OUT_W = 32
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   localparam int EXT_W = IN_W + 1;

   logic signed [EXT_W-1:0]   biased;
   logic signed [EXT_W-1:0]   shifted;
   logic        [EXT_W-OUT_W:0] upper;

   // One guard bit keeps the half-LSB add from wrapping at the positive limit.
   generate
      if (SHIFT > 0) begin : g_round
         localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
         assign biased = {din[IN_W-1], din} + HALF;
      end else begin : g_noround
         assign biased = {din[IN_W-1], din};
      end
   endgenerate

   assign shifted = biased >>> SHIFT;
   assign upper   = shifted[EXT_W-1:OUT_W-1];

   // Result fits only when every bit above the output sign bit equals it.
   always_comb begin
      if (&upper || ~|upper)
         dout = shifted[OUT_W-1:0];
      else if (shifted[EXT_W-1])
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      else
         dout = {1'b0, {(OUT_W-1){1'b1}}};
   end

endmodule

// File: rtl/lsq_coef_solver.sv
// Regression coefficient solver: beta = inv(X'X) * X'Y using one shared
// 34x34 signed multiplier over four cycles, with a one-deep X'Y buffer.
//   clk, rst              : clock, async active-high reset
//   inv_valid, inv00/01/11: inverse terms (level valid)
//   xty_valid, xty0/1     : X'Y sums (one-cycle pulse)
//   beta_valid, beta0/1   : coefficients, pulse on update
//   busy                  : solve in progress
//   xty_ovf               : sticky, X'Y arrived with both slots full
//
// state | meaning
// IDLE  | waiting for both inverse and X'Y operands
// MUL0  | acc0 <= inv00*xty0
// MUL1  | acc0 += inv01*xty1
// MUL2  | acc1 <= inv01*xty0
// MUL3  | acc1 += inv11*xty1
// OUT   | round/saturate into beta, release operands, drain pending X'Y
module lsq_coef_solver
   import lsq_coef_solver_pkg::*;
#(
   parameter int OUT_W    = 32,
   parameter int OUT_FRAC = 16,
   parameter int XTY_FRAC = PRICE_FRAC,
   parameter int INV_FRAC = INV00_FRAC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inv_valid,
   input  logic [INV00_W-1:0]       inv00,
   input  logic [INV01_W-1:0]       inv01,
   input  logic [INV11_W-1:0]       inv11,
   input  logic                     xty_valid,
   input  logic [XTY_W-1:0]         xty0,
   input  logic [XTY_W-1:0]         xty1,
   output logic                     beta_valid,
   output logic signed [OUT_W-1:0]  beta0,
   output logic signed [OUT_W-1:0]  beta1,
   output logic                     busy,
   output logic                     xty_ovf
);

   localparam int SHIFT = INV_FRAC + XTY_FRAC - OUT_FRAC;
   localparam int SH01  = INV_FRAC - INV01_FRAC;
   localparam int SH11  = INV_FRAC - INV11_FRAC;

   state_t                    state;
   logic                      inv_got, xty_got, pend_got;
   logic signed [OPND_W-1:0]  inv00_r, inv01_r, inv11_r;
   logic        [OPND_W-1:0]  xty0_r, xty1_r, pend0_r, pend1_r;
   logic signed [ACC_W-1:0]   acc0, acc1;
   logic signed [OPND_W-1:0]  mul_a, mul_b;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [OUT_W-1:0]   beta0_nx, beta1_nx;

   always_comb begin
      mul_a = inv00_r;
      mul_b = xty0_r;
      case (state)
         MUL1: begin mul_a = inv01_r; mul_b = xty1_r; end
         MUL2: begin mul_a = inv01_r; mul_b = xty0_r; end
         MUL3: begin mul_a = inv11_r; mul_b = xty1_r; end
         default: ;
      endcase
   end

   // X'Y operands are zero-extended, so their top bit is always 0 here.
   assign prod     = mul_a * mul_b;
   assign prod_ext = {prod[PROD_W-1], prod};

   lsq_round_sat #(.IN_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs0 (
      .din  (acc0),
      .dout (beta0_nx)
   );

   lsq_round_sat #(.IN_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs1 (
      .din  (acc1),
      .dout (beta1_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         beta_valid <= 1'b0;
         beta0      <= '0;
         beta1      <= '0;
         xty_ovf    <= 1'b0;
         inv_got    <= 1'b0;
         xty_got    <= 1'b0;
         pend_got   <= 1'b0;
         inv00_r    <= '0;
         inv01_r    <= '0;
         inv11_r    <= '0;
         xty0_r     <= '0;
         xty1_r     <= '0;
         pend0_r    <= '0;
         pend1_r    <= '0;
         acc0       <= '0;
         acc1       <= '0;
      end else begin
         beta_valid <= 1'b0;

         // Align all inverse terms to INV_FRAC fraction bits on capture.
         if (inv_valid && !inv_got) begin
            inv00_r <= {{(OPND_W-INV00_W){inv00[INV00_W-1]}}, inv00};
            inv01_r <= {{(OPND_W-INV01_W-SH01){inv01[INV01_W-1]}}, inv01, {SH01{1'b0}}};
            inv11_r <= {{(OPND_W-INV11_W-SH11){inv11[INV11_W-1]}}, inv11, {SH11{1'b0}}};
            inv_got <= 1'b1;
         end

         // In OUT the main slot is being released, so arrivals are handled there.
         if (state != OUT && xty_valid) begin
            if (!xty_got) begin
               xty0_r  <= zext_xty(xty0);
               xty1_r  <= zext_xty(xty1);
               xty_got <= 1'b1;
            end else if (!pend_got) begin
               pend0_r  <= zext_xty(xty0);
               pend1_r  <= zext_xty(xty1);
               pend_got <= 1'b1;
            end else begin
               xty_ovf <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (inv_got && xty_got) begin
                  state <= MUL0;
                  busy  <= 1'b1;
               end
            end
            MUL0: begin
               acc0  <= prod_ext;
               state <= MUL1;
            end
            MUL1: begin
               acc0  <= acc0 + prod_ext;
               state <= MUL2;
            end
            MUL2: begin
               acc1  <= prod_ext;
               state <= MUL3;
            end
            MUL3: begin
               acc1  <= acc1 + prod_ext;
               state <= OUT;
            end
            OUT: begin
               beta0      <= beta0_nx;
               beta1      <= beta1_nx;
               beta_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
               inv_got    <= 1'b0;
               if (pend_got) begin
                  xty0_r <= pend0_r;
                  xty1_r <= pend1_r;
                  if (xty_valid) begin
                     pend0_r <= zext_xty(xty0);
                     pend1_r <= zext_xty(xty1);
                  end else begin
                     pend_got <= 1'b0;
                  end
               end else if (xty_valid) begin
                  xty0_r <= zext_xty(xty0);
                  xty1_r <= zext_xty(xty1);
               end else begin
                  xty_got <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsq_coef_solver.sv
module tb_lsq_coef_solver;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               inv_valid = 1'b0;
   logic               xty_valid = 1'b0;
   logic [31:0]        inv00 = '0;
   logic [19:0]        inv01 = '0;
   logic [20:0]        inv11 = '0;
   logic [32:0]        xty0 = '0;
   logic [32:0]        xty1 = '0;
   logic               beta_valid, busy, xty_ovf;
   logic signed [31:0] beta0, beta1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsq_coef_solver dut (
      .clk        (clk),
      .rst        (rst),
      .inv_valid  (inv_valid),
      .inv00      (inv00),
      .inv01      (inv01),
      .inv11      (inv11),
      .xty_valid  (xty_valid),
      .xty0       (xty0),
      .xty1       (xty1),
      .beta_valid (beta_valid),
      .beta0      (beta0),
      .beta1      (beta1),
      .busy       (busy),
      .xty_ovf    (xty_ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      inv_valid = 1'b0;
      xty_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic set_inv(input logic [31:0] a, input logic [19:0] b, input logic [20:0] c);
      inv00     = a;
      inv01     = b;
      inv11     = c;
      inv_valid = 1'b1;
   endtask

   task automatic pulse_xty(input logic [32:0] a, input logic [32:0] b);
      xty0      = a;
      xty1      = b;
      xty_valid = 1'b1;
      step();
      xty_valid = 1'b0;
   endtask

   // Edges until beta_valid is seen; 40 means it never came.
   task automatic wait_beta(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!beta_valid && n < 40);
   endtask

   task automatic count_beta(input int cycles, output int c);
      c = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (beta_valid) c++;
      end
   endtask

   initial begin
      int n;
      int c;

      // reset values
      step();
      chk("rst_busy", busy, 32'd0);
      chk("rst_bv", beta_valid, 32'd0);
      chk("rst_b0", beta0, 32'd0);
      chk("rst_b1", beta1, 32'd0);
      chk("rst_ovf", xty_ovf, 32'd0);
      rst = 1'b0;
      step();

      // identity inverse, cycle-by-cycle
      do_reset();
      set_inv(32'd1024, 20'd0, 21'd64);
      step();
      inv_valid = 1'b0;
      pulse_xty(33'd768, 33'd1280);
      chk("id_busy_e0", busy, 32'd0);
      step();
      chk("id_busy_e1", busy, 32'd1);
      repeat (3) step();
      step();
      chk("id_bv_e5", beta_valid, 32'd0);
      chk("id_busy_e5", busy, 32'd1);
      step();
      chk("id_bv_e6", beta_valid, 32'd1);
      chk("id_b0", beta0, 32'd196608);
      chk("id_b1", beta1, 32'd327680);
      step();
      chk("id_bv_e7", beta_valid, 32'd0);
      chk("id_b0_hold", beta0, 32'd196608);
      chk("id_busy_e7", busy, 32'd0);

      // negative off-diagonal, inverse held high and reused
      do_reset();
      set_inv(32'd1024, 20'hFFF00, 21'd64);
      pulse_xty(33'd256, 33'd256);
      wait_beta(n);
      chk("neg_lat", n, 32'd6);
      chk("neg_b0_zero", beta0, 32'd0);
      chk("neg_b1_zero", beta1, 32'd0);
      pulse_xty(33'd256, 33'd512);
      wait_beta(n);
      chk("neg2_lat", n, 32'd6);
      chk("neg2_b0", beta0, 32'hFFFF0000);
      chk("neg2_b1", beta1, 32'd65536);
      inv_valid = 1'b0;

      // X'Y first, inverse 10 cycles later
      do_reset();
      pulse_xty(33'd768, 33'd1280);
      repeat (9) step();
      chk("ord_xfirst_idle", busy, 32'd0);
      set_inv(32'd1024, 20'd0, 21'd64);
      step();
      inv_valid = 1'b0;
      wait_beta(n);
      chk("ord_xfirst_lat", n, 32'd6);
      chk("ord_xfirst_b0", beta0, 32'd196608);

      // inverse first
      do_reset();
      set_inv(32'd1024, 20'd0, 21'd64);
      step();
      inv_valid = 1'b0;
      repeat (4) step();
      chk("ord_ifirst_idle", busy, 32'd0);
      pulse_xty(33'd256, 33'd512);
      wait_beta(n);
      chk("ord_ifirst_lat", n, 32'd6);
      chk("ord_ifirst_b0", beta0, 32'd65536);
      chk("ord_ifirst_b1", beta1, 32'd131072);

      // buffering and overflow
      do_reset();
      set_inv(32'd1024, 20'd0, 21'd64);
      pulse_xty(33'd768, 33'd1280);
      pulse_xty(33'd256, 33'd512);
      chk("buf_busy", busy, 32'd1);
      chk("buf_ovf_before", xty_ovf, 32'd0);
      pulse_xty(33'd1024, 33'd1024);
      chk("buf_ovf_set", xty_ovf, 32'd1);
      wait_beta(n);
      chk("buf_lat1", n, 32'd4);
      chk("buf_first_b0", beta0, 32'd196608);
      chk("buf_first_b1", beta1, 32'd327680);
      wait_beta(n);
      chk("buf_lat2", n, 32'd7);
      chk("buf_second_b0", beta0, 32'd65536);
      chk("buf_second_b1", beta1, 32'd131072);
      count_beta(20, c);
      chk("buf_no_third", c, 32'd0);
      chk("buf_ovf_sticky", xty_ovf, 32'd1);
      inv_valid = 1'b0;
      do_reset();
      chk("buf_ovf_cleared", xty_ovf, 32'd0);

      // positive saturation
      do_reset();
      set_inv(32'h7FFFFFFF, 20'd0, 21'd0);
      pulse_xty(33'h1FFFFFFFF, 33'd0);
      inv_valid = 1'b0;
      wait_beta(n);
      chk("satp_lat", n, 32'd6);
      chk("satp_b0", beta0, 32'h7FFFFFFF);
      chk("satp_b1", beta1, 32'd0);

      // negative saturation
      do_reset();
      set_inv(32'd0, 20'h80000, 21'd0);
      pulse_xty(33'd0, 33'h1FFFFFFFF);
      inv_valid = 1'b0;
      wait_beta(n);
      chk("satn_b0", beta0, 32'h80000000);
      chk("satn_b1", beta1, 32'd0);

      // half-up rounding: +0.5 LSB rounds to 1, -0.5 LSB rounds to 0
      do_reset();
      set_inv(32'd1, 20'd0, 21'd0);
      pulse_xty(33'd2, 33'd0);
      inv_valid = 1'b0;
      wait_beta(n);
      chk("rnd_pos_half", beta0, 32'd1);
      do_reset();
      set_inv(32'hFFFFFFFF, 20'd0, 21'd0);
      pulse_xty(33'd2, 33'd0);
      inv_valid = 1'b0;
      wait_beta(n);
      chk("rnd_neg_half", beta0, 32'd0);

      // asynchronous reset in MUL2 of the second (pending) solve
      do_reset();
      set_inv(32'd1024, 20'd0, 21'd64);
      pulse_xty(33'd768, 33'd1280);
      pulse_xty(33'd256, 33'd512);
      pulse_xty(33'd1024, 33'd1024);
      wait_beta(n);
      chk("arst_pre_b0", beta0, 32'd196608);
      repeat (4) step();
      chk("arst_pre_busy", busy, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 32'd0);
      chk("arst_bv", beta_valid, 32'd0);
      chk("arst_b0", beta0, 32'd0);
      chk("arst_b1", beta1, 32'd0);
      chk("arst_ovf", xty_ovf, 32'd0);
      inv_valid = 1'b0;
      step();
      rst = 1'b0;
      count_beta(20, c);
      chk("arst_no_beta", c, 32'd0);
      chk("arst_idle", busy, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
